vec_result_serializer: RTL



---
 rtl/vec_result_serializer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vec_result_serializer.sv
// vec_result_serializer
//
// Captures one set of six vector results (res1..res4 wide, res5..res6 narrow)
// with a valid/ready handshake and streams them out as a byte-wide frame. Byte
// order is res1..res6, each MSB byte first. Completed frames are counted in a
// wrapping 16-bit counter.
//
// Optional feature: define VEC_SER_CHECKSUM_EN to append one extra byte, the XOR
// of all data bytes. tx_last then marks the checksum byte only.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     result set on res1..res6 is valid
//   in_ready     block can capture a result set (IDLE and not in reset)
//   res1..res4   wide results, WIDE_W bits
//   res5..res6   narrow results, NARROW_W bits
//   tx_valid     tx_data holds a valid byte
//   tx_ready     sink accepts the byte
//   tx_data      current frame byte
//   tx_last      current byte is the last byte of the frame
//   busy         frame in progress
//   frames_sent  count of completed frames, wraps

module vec_result_serializer #(
  parameter int unsigned WIDE_W   = 16,
  parameter int unsigned NARROW_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE_W-1:0]   res1,
  input  logic [WIDE_W-1:0]   res2,
  input  logic [WIDE_W-1:0]   res3,
  input  logic [WIDE_W-1:0]   res4,
  input  logic [NARROW_W-1:0] res5,
  input  logic [NARROW_W-1:0] res6,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_last,
  output logic                busy,
  output logic [15:0]         frames_sent
);

  localparam int unsigned NData = (4 * WIDE_W + 2 * NARROW_W) / 8;
`ifdef VEC_SER_CHECKSUM_EN
  localparam int unsigned NTotal = NData + 1;
`else
  localparam int unsigned NTotal = NData;
`endif
  localparam int unsigned  FrameW  = NTotal * 8;
  localparam int unsigned  IdxW    = $clog2(NTotal);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NTotal - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   frame_q;
  logic [IdxW-1:0]     idx_q;
  logic [15:0]         frames_q;

  logic [NData*8-1:0]  data_in;
  logic [FrameW-1:0]   load_val;
  logic                capture;
  logic                send_hs;
  logic                at_last;

  assign data_in = {res1, res2, res3, res4, res5, res6};

`ifdef VEC_SER_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < int'(NData); i++) begin
      csum = csum ^ data_in[i*8 +: 8];
    end
  end

  assign load_val = {data_in, csum};
`else
  assign load_val = data_in;
`endif

  assign capture = in_valid && (state_q == StIdle);
  assign send_hs = (state_q == StSend) && tx_ready;
  assign at_last = (idx_q == LastIdx);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StSend;
      StSend:  if (send_hs && at_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Frame shift register, byte index and frame counter. The frame is shifted
  // left on each accepted byte so the outgoing byte is always the top byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q  <= '0;
      idx_q    <= '0;
      frames_q <= '0;
    end else if (capture) begin
      frame_q <= load_val;
      idx_q   <= '0;
    end else if (send_hs) begin
      frame_q <= {frame_q[FrameW-9:0], 8'h00};
      if (at_last) begin
        idx_q    <= '0;
        frames_q <= frames_q + 16'd1;
      end else begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      StIdle: in_ready = ~rst;
      StSend: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_last  = at_last;
        tx_data  = frame_q[FrameW-1 -: 8];
      end
      default: ;
    endcase
  end

  assign frames_sent = frames_q;

endmodule
